// File: rtl/ecc_scrub_pkg.sv
// ecc_scrub_pkg: shared widths, field slices and FSM states for the ECC scrubber.
package ecc_scrub_pkg;
    localparam int DATA_W   = 32;
    localparam int CHK_W    = 8;
    localparam int WORD_W   = DATA_W + CHK_W;
    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = DATA_W - 1;
    localparam int CHK_LSB  = DATA_W;
    localparam int CHK_MSB  = WORD_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_CHECK,
        S_WB,
        S_GAP
    } scrub_state_e;
endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// ecc_scrub_ctrl_if: memory port between the scrubber (master) and the arbiter (slave).
interface ecc_scrub_ctrl_if
    import ecc_scrub_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [WORD_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [WORD_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/ecc_scrub_gap_timer.sv
// ecc_scrub_gap_timer: loadable down-counter; expired_o is high once the count reaches zero.
module ecc_scrub_gap_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         expired_o
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (load_i)
            r_cnt <= val_i;
        else if (|r_cnt)
            r_cnt <= r_cnt - 1'b1;
    end

    assign expired_o = (r_cnt == '0);
endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background scrubber walking an ECC memory and writing back corrected words.
// Define ECC_SCRUB_MASK_EN to register the bit mask of the most recent correction on err_mask_o.
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DEPTH      = 1024,
    parameter int INTERVAL_W = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [INTERVAL_W-1:0] interval_i,
    input  logic                  clr_i,
    output logic                  busy_o,
    output logic                  done_o,
    ecc_scrub_ctrl_if.master      mem,
    output logic                  corr_en_o,
    output logic [DATA_W-1:0]     corr_data_o,
    output logic [CHK_W-1:0]      corr_chk_o,
    input  logic [DATA_W-1:0]     corr_data_i,
    output logic [CNT_W-1:0]      err_cnt_o,
    output logic [ADDR_W-1:0]     err_addr_o,
    output logic                  err_flag_o,
    output logic [DATA_W-1:0]     err_mask_o
);
    scrub_state_e          r_state, w_next;
    logic [ADDR_W-1:0]     r_addr, r_err_addr;
    logic [INTERVAL_W-1:0] r_ivl;
    logic [WORD_W-1:0]     r_raw, r_wdata;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy, r_done, r_req, r_we, r_flag;
    logic [DATA_W-1:0]     w_diff;
    logic                  w_hit, w_last, w_expired, w_load;

    assign w_diff = corr_data_i ^ r_raw[DATA_MSB:DATA_LSB];
    assign w_hit  = (r_state == S_CHECK) && (|w_diff);
    assign w_last = (r_addr == ADDR_W'(DEPTH - 1));
    assign w_load = (w_next == S_GAP) && (r_state != S_GAP);

    ecc_scrub_gap_timer #(.W(INTERVAL_W)) u_gap (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (w_load),
        .val_i     (r_ivl),
        .expired_o (w_expired)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    w_next = start_i ? S_RD_REQ : S_IDLE;
            S_RD_REQ:  w_next = mem.mem_gnt_i ? S_RD_WAIT : S_RD_REQ;
            S_RD_WAIT: w_next = mem.mem_rvalid_i ? S_CHECK : S_RD_WAIT;
            S_CHECK:   w_next = w_hit ? S_WB : S_GAP;
            S_WB:      w_next = mem.mem_gnt_i ? S_GAP : S_WB;
            S_GAP:     w_next = !w_expired ? S_GAP : (w_last ? S_IDLE : S_RD_REQ);
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Request outputs are registered from the next state so they hold steady through a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_addr     <= '0;
            r_ivl      <= '0;
            r_raw      <= '0;
            r_wdata    <= '0;
            r_err_addr <= '0;
        end else begin
            r_req  <= (w_next == S_RD_REQ) || (w_next == S_WB);
            r_we   <= (w_next == S_WB);
            r_done <= (r_state == S_GAP) && w_expired && w_last;
            if (r_state == S_IDLE && start_i) begin
                r_ivl  <= interval_i;
                r_addr <= '0;
                r_busy <= 1'b1;
            end
            if (r_state == S_GAP && w_expired) begin
                if (w_last)
                    r_busy <= 1'b0;
                else
                    r_addr <= r_addr + 1'b1;
            end
            if (r_state == S_RD_WAIT && mem.mem_rvalid_i)
                r_raw <= mem.mem_rdata_i;
            if (w_hit) begin
                r_wdata    <= {r_raw[CHK_MSB:CHK_LSB], corr_data_i};
                r_err_addr <= r_addr;
            end
        end
    end

    // A clear in the same cycle as a correction wins over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (clr_i) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (w_hit) begin
            r_cnt  <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
            r_flag <= 1'b1;
        end
    end

`ifdef ECC_SCRUB_MASK_EN
    logic [DATA_W-1:0] r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mask <= '0;
        else if (clr_i)
            r_mask <= '0;
        else if (w_hit)
            r_mask <= w_diff;
    end

    assign err_mask_o = r_mask;
`else
    assign err_mask_o = '0;
`endif

    assign mem.mem_req_o   = r_req;
    assign mem.mem_we_o    = r_we;
    assign mem.mem_addr_o  = r_addr;
    assign mem.mem_wdata_o = r_wdata;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign corr_en_o       = (r_state == S_CHECK);
    assign corr_data_o     = corr_en_o ? r_raw[DATA_MSB:DATA_LSB] : '0;
    assign corr_chk_o      = corr_en_o ? r_raw[CHK_MSB:CHK_LSB] : '0;
    assign err_cnt_o       = r_cnt;
    assign err_addr_o      = r_err_addr;
    assign err_flag_o      = r_flag;
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl: directed bench with a memory responder and a tag-indexed corrector model.
module tb_ecc_scrub_ctrl;
    localparam int AW = 4;
    localparam int DP = 6;
    localparam int IW = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          clr_i = 1'b0;
    logic [IW-1:0] interval_i = '0;
    logic          busy_o, done_o, corr_en_o, err_flag_o;
    logic [31:0]   corr_data_o, corr_data_i, err_mask_o;
    logic [7:0]    corr_chk_o;
    logic [CW-1:0] err_cnt_o;
    logic [AW-1:0] err_addr_o;

    ecc_scrub_ctrl_if #(.ADDR_W(AW)) mif ();

    ecc_scrub_ctrl #(.ADDR_W(AW), .DEPTH(DP), .INTERVAL_W(IW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .interval_i  (interval_i),
        .clr_i       (clr_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mem         (mif),
        .corr_en_o   (corr_en_o),
        .corr_data_o (corr_data_o),
        .corr_chk_o  (corr_chk_o),
        .corr_data_i (corr_data_i),
        .err_cnt_o   (err_cnt_o),
        .err_addr_o  (err_addr_o),
        .err_flag_o  (err_flag_o),
        .err_mask_o  (err_mask_o)
    );

    always #5 clk = ~clk;

    // Check byte 0xA0|addr tags each word, so the corrector model knows the good data.
    function automatic logic [31:0] gold(input int a);
        return 32'hC0DE_0000 + 32'h1111 * 32'(a);
    endfunction

    assign corr_data_i = corr_en_o ? gold(int'(corr_chk_o[2:0])) : 32'h0;

    logic [39:0]   mem [16];
    int            gnt_dly = 0, wait_cnt = 0, n_rd = 0, n_wr = 0;
    logic          pend = 1'b0;
    logic [39:0]   pend_d = '0, last_wd = '0;
    logic [AW-1:0] last_wa = '0, first_ra = '0;

    always @(negedge clk) begin
        mif.mem_rvalid_i = pend;
        mif.mem_rdata_i  = pend_d;
        pend = 1'b0;
        if (!rst_n || !mif.mem_req_o) begin
            mif.mem_gnt_i = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt < gnt_dly) begin
            mif.mem_gnt_i = 1'b0;
            wait_cnt++;
        end else begin
            mif.mem_gnt_i = 1'b1;
            wait_cnt = 0;
            if (mif.mem_we_o) begin
                mem[mif.mem_addr_o] = mif.mem_wdata_o;
                last_wa = mif.mem_addr_o;
                last_wd = mif.mem_wdata_o;
                n_wr++;
            end else begin
                if (n_rd == 0) first_ra = mif.mem_addr_o;
                pend   = 1'b1;
                pend_d = mem[mif.mem_addr_o];
                n_rd++;
            end
        end
    end

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    bit          mon_en = 1'b0;
    logic        p_stall = 1'b0;
    logic [45:0] prev = '0;
    int          n_stall = 0;

    always @(negedge clk) begin
        #2;
        if (mon_en && p_stall) begin
            n_stall++;
            chk("stall_hold", 128'({mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o}), 128'(prev));
        end
        prev    = {mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o};
        p_stall = mif.mem_req_o && !mif.mem_gnt_i;
    end

    task automatic init_mem(input logic [15:0] bad, input logic [31:0] flip);
        for (int a = 0; a < 16; a++)
            mem[a] = {8'hA0 | 8'(a), gold(a) ^ (bad[a] ? flip : 32'h0)};
    endtask

    task automatic run_pass(input int dly, input logic [IW-1:0] ivl, input bit mid_start,
                            output int cyc, output int dones);
        gnt_dly = dly;
        n_rd = 0;
        n_wr = 0;
        cyc = 0;
        dones = 0;
        @(negedge clk);
        interval_i = ivl;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        interval_i = '0;
        for (int c = 0; c < 400 && dones == 0; c++) begin
            #1;
            if (busy_o) cyc++;
            if (done_o) begin
                dones++;
                chk("busy_falls_with_done", 128'(busy_o), 128'(0));
            end
            start_i = mid_start && cyc == 10;
            @(negedge clk);
        end
        start_i = 1'b0;
        repeat (3) begin
            #1;
            if (done_o) dones++;
            @(negedge clk);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {busy_o, done_o, mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o, mif.mem_wdata_o,
                corr_en_o, corr_data_o, corr_chk_o, err_cnt_o, err_addr_o, err_flag_o, err_mask_o};
    endfunction

    int cyc, dn, nd;

    initial begin
        init_mem(16'h0, 32'h0);
        repeat (3) @(negedge clk);
        #1 chk("reset_outputs", all_outs(), 128'(0));
        rst_n = 1'b1;
        #1 chk("post_reset_idle", all_outs(), 128'(0));

        // clean pass, grant one cycle after request: 5 cycles per word
        run_pass(1, 4'd0, 1'b0, cyc, dn);
        chk("clean_cycles", 128'(cyc), 128'(30));
        chk("clean_done", 128'(dn), 128'(1));
        chk("clean_reads", 128'(n_rd), 128'(6));
        chk("clean_writes", 128'(n_wr), 128'(0));
        chk("clean_err", 128'({err_cnt_o, err_flag_o}), 128'(0));

        // word 2 data bit 5 flipped, zero-latency grant: 6*4 + 1 writeback cycle
        init_mem(16'h0004, 32'h0000_0020);
        run_pass(0, 4'd0, 1'b0, cyc, dn);
        chk("fix_cycles", 128'(cyc), 128'(25));
        chk("fix_done", 128'(dn), 128'(1));
        chk("fix_writes", 128'(n_wr), 128'(1));
        chk("fix_wr_addr", 128'(last_wa), 128'(2));
        chk("fix_wr_data", 128'(last_wd), 128'(40'hA2_C0DE_2222));
        chk("fix_mem2", 128'(mem[2]), 128'(40'hA2_C0DE_2222));
        chk("fix_cnt", 128'(err_cnt_o), 128'(1));
        chk("fix_addr", 128'(err_addr_o), 128'(2));
        chk("fix_flag", 128'(err_flag_o), 128'(1));
`ifdef ECC_SCRUB_MASK_EN
        chk("fix_mask", 128'(err_mask_o), 128'(32'h0000_0020));
`else
        chk("fix_mask", 128'(err_mask_o), 128'(0));
`endif

        @(negedge clk);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        #1;
        chk("clr_cnt_flag_mask", 128'({err_cnt_o, err_flag_o, err_mask_o}), 128'(0));
        chk("clr_keeps_addr", 128'(err_addr_o), 128'(2));

        // interval 3 adds 3 GAP cycles per word; mid-pass start is ignored
        init_mem(16'h0, 32'h0);
        run_pass(0, 4'd3, 1'b1, cyc, dn);
        chk("ivl_cycles", 128'(cyc), 128'(42));
        chk("ivl_done", 128'(dn), 128'(1));
        chk("ivl_reads", 128'(n_rd), 128'(6));

        // grant stalled 5 cycles on every request, including the writeback
        init_mem(16'h0004, 32'h0000_0020);
        mon_en = 1'b1;
        run_pass(5, 4'd0, 1'b0, cyc, dn);
        mon_en = 1'b0;
        chk("stall_cycles", 128'(cyc), 128'(60));
        chk("stall_checks", 128'(n_stall), 128'(35));
        chk("stall_writes", 128'(n_wr), 128'(1));
        chk("stall_mem2", 128'(mem[2]), 128'(40'hA2_C0DE_2222));

        // every word corrupted: 2-bit counter saturates at 3
        init_mem(16'h003F, 32'h8000_0000);
        run_pass(0, 4'd0, 1'b0, cyc, dn);
        chk("sat_cycles", 128'(cyc), 128'(30));
        chk("sat_writes", 128'(n_wr), 128'(6));
        chk("sat_cnt", 128'(err_cnt_o), 128'(3));
        chk("sat_addr", 128'(err_addr_o), 128'(5));
`ifdef ECC_SCRUB_MASK_EN
        chk("sat_mask", 128'(err_mask_o), 128'(32'h8000_0000));
`else
        chk("sat_mask", 128'(err_mask_o), 128'(0));
`endif

        // clear coinciding with the only correction of the pass: clear wins
        init_mem(16'h0001, 32'h0000_0001);
        fork
            run_pass(0, 4'd0, 1'b0, cyc, dn);
            begin
                for (int i = 0; i < 60 && !corr_en_o; i++) begin
                    @(negedge clk);
                    #1;
                end
                clr_i = 1'b1;
                @(negedge clk);
                clr_i = 1'b0;
            end
        join
        chk("clrhit_cnt_flag", 128'({err_cnt_o, err_flag_o}), 128'(0));
        chk("clrhit_writes", 128'(n_wr), 128'(1));

        // asynchronous reset while waiting for read data of word 1
        init_mem(16'h0, 32'h0);
        gnt_dly = 0;
        n_rd = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (mif.mem_gnt_i && !mif.mem_we_o && mif.mem_addr_o == 4'd1) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("abort_outputs", all_outs(), 128'(0));
        nd = 0;
        repeat (2) begin
            @(negedge clk);
            #1 if (done_o) nd++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1 if (done_o) nd++;
        end
        chk("abort_no_done", 128'(nd), 128'(0));
        run_pass(0, 4'd0, 1'b0, cyc, dn);
        chk("restart_first_addr", 128'(first_ra), 128'(0));
        chk("restart_reads", 128'(n_rd), 128'(6));
        chk("restart_cycles", 128'(cyc), 128'(24));
        chk("restart_done", 128'(dn), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
